// File: rtl/cpu_pkg.sv
// Shared types for the fetch path: run-control states and architectural PC width.
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } run_state_t;

   localparam int PC_W = 32;

endpackage

// File: rtl/icache_dp.sv
// Simple dual-port instruction RAM: one write port, one synchronous read port, no reset.
module icache_dp #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 16
) (
   input  logic               clk,
   input  logic               we,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [INSTR_W-1:0] wr_data,
   input  logic [ADDR_W-1:0]  rd_addr,
   output logic [INSTR_W-1:0] rd_data
);

   logic [INSTR_W-1:0] mem_r [2**ADDR_W];

   // Write port plus registered read; a same-address read returns the old word.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[wr_addr] <= wr_data;
      end
      rd_data <= mem_r[rd_addr];
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch path: instruction memory, program counter and run/halt/step control.
// The RAM is read at the next PC so that instr always matches pc in the same cycle.
module fetch_ctrl
   import cpu_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter int INSTR_W    = 16,
   parameter bit SWAP_BYTES = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load_valid,
   output logic               load_ready,
   input  logic [ADDR_W-1:0]  load_addr,
   input  logic [INSTR_W-1:0] load_data,
   input  logic               run_cmd,
   input  logic               halt_cmd,
   input  logic               step_cmd,
   input  logic               bp_enable,
   input  logic [ADDR_W-1:0]  bp_addr,
   input  logic [31:0]        delta_i,
   output logic [INSTR_W-1:0] instr,
   output logic               instr_valid,
   output logic               core_en,
   output logic [PC_W-1:0]    pc,
   output logic [1:0]         state
);

   localparam int NBYTES = INSTR_W / 8;

   run_state_t         state_r, state_d_s;
   logic [ADDR_W-1:0]  pc_r, pc_d_s, pc_inc_s;
   logic               core_en_r, core_en_d_s;
   logic               rd_ok_r;
   logic               wr_en_s;
   logic [INSTR_W-1:0] rd_data_s, swapped_s;

   // PC successor: low ADDR_W bits of pc + delta, so negative deltas wrap.
   always_comb begin
      pc_inc_s = ADDR_W'({{(PC_W-ADDR_W){1'b0}}, pc_r} + delta_i);
   end

   // Next-state, next-PC and next-enable decode of the run-control FSM.
   always_comb begin
      state_d_s   = state_r;
      pc_d_s      = pc_r;
      core_en_d_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (run_cmd) begin
               state_d_s   = RUN;
               pc_d_s      = {ADDR_W{1'b0}};
               core_en_d_s = 1'b1;
            end else begin
               state_d_s   = IDLE;
            end
         end
         RUN: begin
            pc_d_s = pc_inc_s;
            if (bp_enable && (pc_inc_s == bp_addr)) begin
               state_d_s   = HALT;
            end else if (halt_cmd) begin
               state_d_s   = HALT;
            end else begin
               core_en_d_s = 1'b1;
            end
         end
         HALT: begin
            // core_en high while halted marks the single-step cycle
            if (core_en_r) begin
               pc_d_s      = pc_inc_s;
            end else if (halt_cmd) begin
               state_d_s   = HALT;
            end else if (run_cmd) begin
               state_d_s   = RUN;
               core_en_d_s = 1'b1;
            end else if (step_cmd) begin
               core_en_d_s = 1'b1;
            end else begin
               core_en_d_s = 1'b0;
            end
         end
         default: begin
            state_d_s   = IDLE;
            pc_d_s      = {ADDR_W{1'b0}};
         end
      endcase
   end

   // Run-control state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= IDLE;
         pc_r      <= {ADDR_W{1'b0}};
         core_en_r <= 1'b0;
         rd_ok_r   <= 1'b0;
      end else begin
         state_r   <= state_d_s;
         pc_r      <= pc_d_s;
         core_en_r <= core_en_d_s;
         rd_ok_r   <= 1'b1;
      end
   end

   assign load_ready = (state_r != RUN);
   assign wr_en_s    = load_valid & load_ready & ~reset;

   icache_dp #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W)
   ) u_icache (
      .clk     (clk),
      .we      (wr_en_s),
      .wr_addr (load_addr),
      .wr_data (load_data),
      .rd_addr (pc_d_s),
      .rd_data (rd_data_s)
   );

   generate
      if (SWAP_BYTES) begin : g_swap
         for (genvar k = 0; k < NBYTES; k++) begin : g_byte
            assign swapped_s[8*k +: 8] = rd_data_s[8*(NBYTES-1-k) +: 8];
         end
      end else begin : g_pass
         assign swapped_s = rd_data_s;
      end
   endgenerate

   assign instr       = rd_ok_r ? swapped_s : {INSTR_W{1'b0}};
   assign core_en     = core_en_r;
   assign instr_valid = core_en_r;
   assign pc          = {{(PC_W-ADDR_W){1'b0}}, pc_r};
   assign state       = state_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed, table-driven bench for fetch_ctrl (ADDR_W=8, INSTR_W=16, SWAP_BYTES=1).
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        load_valid, load_ready;
   logic [7:0]  load_addr;
   logic [15:0] load_data;
   logic        run_cmd, halt_cmd, step_cmd, bp_enable;
   logic [7:0]  bp_addr;
   logic [31:0] delta_i;
   logic [15:0] instr;
   logic        instr_valid, core_en;
   logic [31:0] pc;
   logic [1:0]  state;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct packed {
      logic        run, halt, step, bp_en;
      logic [7:0]  bp_a;
      logic [31:0] delta;
      logic [31:0] exp_pc;
      logic [15:0] exp_instr;
      logic        chk_instr;
      logic        exp_en;
      logic [1:0]  exp_state;
   } vec_t;

   vec_t vecs[$];

   fetch_ctrl #(.ADDR_W(8), .INSTR_W(16), .SWAP_BYTES(1'b1)) dut (
      .clk(clk), .reset(reset),
      .load_valid(load_valid), .load_ready(load_ready),
      .load_addr(load_addr), .load_data(load_data),
      .run_cmd(run_cmd), .halt_cmd(halt_cmd), .step_cmd(step_cmd),
      .bp_enable(bp_enable), .bp_addr(bp_addr), .delta_i(delta_i),
      .instr(instr), .instr_valid(instr_valid), .core_en(core_en),
      .pc(pc), .state(state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic load_word(input logic [7:0] a, input logic [15:0] d);
      int w;
      w = 0;
      load_valid = 1'b1;
      load_addr  = a;
      load_data  = d;
      while (!load_ready && w < 20) begin
         tick();
         w++;
      end
      chk("load_ready_wait", 32'(load_ready), 32'd1);
      tick();
      load_valid = 1'b0;
   endtask

   task automatic add(input logic r, input logic h, input logic s, input logic be,
                      input logic [7:0] ba, input logic [31:0] d, input logic [31:0] epc,
                      input logic [15:0] ei, input logic ci, input logic en, input logic [1:0] st);
      vec_t v;
      v.run = r; v.halt = h; v.step = s; v.bp_en = be; v.bp_a = ba; v.delta = d;
      v.exp_pc = epc; v.exp_instr = ei; v.chk_instr = ci; v.exp_en = en; v.exp_state = st;
      vecs.push_back(v);
   endtask

   initial begin
      reset = 1'b1; load_valid = 1'b0; load_addr = 8'd0; load_data = 16'd0;
      run_cmd = 1'b0; halt_cmd = 1'b0; step_cmd = 1'b0; bp_enable = 1'b0;
      bp_addr = 8'd0; delta_i = 32'd1;
      tick();
      tick();
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_pc", pc, 32'd0);
      chk("rst_instr", 32'(instr), 32'd0);
      chk("rst_core_en", 32'(core_en), 32'd0);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      chk("rst_load_ready", 32'(load_ready), 32'd1);
      reset = 1'b0;

      load_word(8'd0, 16'h3412);
      load_word(8'd1, 16'h7856);
      load_word(8'd2, 16'hBC9A);
      load_word(8'd3, 16'hF0DE);
      for (int k = 4; k < 10; k++) load_word(8'(k), {8'hEE, 8'(k)});

      //   run   halt  step  bp    bpa   delta         pc      instr     ci    en    st
      add(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 32'd1,        32'd0,  16'h1234, 1'b1, 1'b1, 2'd1);
      add(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd1,        32'd1,  16'h5678, 1'b1, 1'b1, 2'd1);
      add(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd1,        32'd2,  16'h9ABC, 1'b1, 1'b1, 2'd1);
      add(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd1,        32'd3,  16'hDEF0, 1'b1, 1'b1, 2'd1);
      add(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 32'hFFFFFFFF, 32'd2,  16'h9ABC, 1'b1, 1'b1, 2'd1);
      add(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 32'hFFFFFFFD, 32'd255,16'h0000, 1'b0, 1'b1, 2'd1);
      add(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd1,        32'd0,  16'h1234, 1'b1, 1'b1, 2'd1);
      add(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd1,        32'd1,  16'h5678, 1'b1, 1'b1, 2'd1);
      add(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 32'd1,        32'd2,  16'h9ABC, 1'b1, 1'b0, 2'd2);
      add(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd1,        32'd2,  16'h9ABC, 1'b1, 1'b0, 2'd2);
      add(1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 32'd1,        32'd2,  16'h9ABC, 1'b1, 1'b1, 2'd1);
      add(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd1,        32'd3,  16'hDEF0, 1'b1, 1'b1, 2'd1);
      add(1'b0, 1'b0, 1'b0, 1'b1, 8'd5, 32'd1,        32'd4,  16'h04EE, 1'b1, 1'b1, 2'd1);
      add(1'b0, 1'b0, 1'b0, 1'b1, 8'd5, 32'd1,        32'd5,  16'h05EE, 1'b1, 1'b0, 2'd2);
      add(1'b0, 1'b0, 1'b0, 1'b1, 8'd5, 32'd1,        32'd5,  16'h05EE, 1'b1, 1'b0, 2'd2);
      add(1'b0, 1'b0, 1'b1, 1'b1, 8'd5, 32'd1,        32'd5,  16'h05EE, 1'b1, 1'b1, 2'd2);
      add(1'b0, 1'b0, 1'b0, 1'b1, 8'd5, 32'd1,        32'd6,  16'h06EE, 1'b1, 1'b0, 2'd2);
      add(1'b0, 1'b0, 1'b0, 1'b1, 8'd5, 32'd1,        32'd6,  16'h06EE, 1'b1, 1'b0, 2'd2);
      add(1'b1, 1'b1, 1'b0, 1'b1, 8'd5, 32'd1,        32'd6,  16'h06EE, 1'b1, 1'b0, 2'd2);
      add(1'b1, 1'b0, 1'b0, 1'b1, 8'd5, 32'd1,        32'd6,  16'h06EE, 1'b1, 1'b1, 2'd1);
      add(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd1,        32'd7,  16'h07EE, 1'b1, 1'b1, 2'd1);
      add(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 32'd1,        32'd8,  16'h08EE, 1'b1, 1'b1, 2'd1);

      foreach (vecs[i]) begin
         run_cmd = vecs[i].run; halt_cmd = vecs[i].halt; step_cmd = vecs[i].step;
         bp_enable = vecs[i].bp_en; bp_addr = vecs[i].bp_a; delta_i = vecs[i].delta;
         tick();
         chk($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
         chk($sformatf("v%0d_core_en", i), 32'(core_en), 32'(vecs[i].exp_en));
         chk($sformatf("v%0d_instr_valid", i), 32'(instr_valid), 32'(vecs[i].exp_en));
         chk($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
         if (vecs[i].chk_instr) chk($sformatf("v%0d_instr", i), 32'(instr), 32'(vecs[i].exp_instr));
      end
      run_cmd = 1'b0; halt_cmd = 1'b0; step_cmd = 1'b0; bp_enable = 1'b0;

      // Download stalled during RUN, then written once halted at the same address as pc.
      delta_i = 32'd0; load_valid = 1'b1; load_addr = 8'd8; load_data = 16'h3CA5;
      tick();
      chk("stall_ready", 32'(load_ready), 32'd0);
      chk("stall_instr", 32'(instr), 32'h08EE);
      tick();
      chk("stall_ready2", 32'(load_ready), 32'd0);
      chk("stall_instr2", 32'(instr), 32'h08EE);
      halt_cmd = 1'b1;
      tick();
      halt_cmd = 1'b0;
      chk("halt_state", 32'(state), 32'd2);
      chk("halt_ready", 32'(load_ready), 32'd1);
      chk("halt_instr_old", 32'(instr), 32'h08EE);
      tick();
      load_valid = 1'b0;
      chk("wr_plus1_old", 32'(instr), 32'h08EE);
      tick();
      chk("wr_plus2_new", 32'(instr), 32'hA53C);

      // Resume while parked on the breakpoint address proceeds.
      bp_enable = 1'b1; bp_addr = 8'd8; run_cmd = 1'b1; delta_i = 32'd1;
      tick();
      run_cmd = 1'b0;
      chk("resume_bp_pc", pc, 32'd8);
      chk("resume_bp_en", 32'(core_en), 32'd1);
      chk("resume_bp_instr", 32'(instr), 32'hA53C);
      tick();
      chk("resume_next_pc", pc, 32'd9);
      chk("resume_next_state", 32'(state), 32'd1);
      chk("resume_next_instr", 32'(instr), 32'h09EE);
      bp_enable = 1'b0;

      // Asynchronous reset mid-RUN at pc 7; memory contents must survive.
      delta_i = 32'hFFFFFFFE;
      tick();
      chk("pre_rst_pc", pc, 32'd7);
      delta_i = 32'd1;
      #2;
      reset = 1'b1;
      load_valid = 1'b1; load_addr = 8'd1; load_data = 16'hFFFF;
      #1;
      chk("async_rst_en", 32'(core_en), 32'd0);
      chk("async_rst_pc", pc, 32'd0);
      chk("async_rst_state", 32'(state), 32'd0);
      chk("async_rst_instr", 32'(instr), 32'd0);
      tick();
      tick();
      reset = 1'b0; load_valid = 1'b0;
      step_cmd = 1'b1; halt_cmd = 1'b1;
      tick();
      step_cmd = 1'b0; halt_cmd = 1'b0;
      chk("idle_ignore_state", 32'(state), 32'd0);
      chk("idle_ignore_en", 32'(core_en), 32'd0);
      run_cmd = 1'b1;
      tick();
      run_cmd = 1'b0;
      chk("post_rst_pc", pc, 32'd0);
      chk("post_rst_en", 32'(core_en), 32'd1);
      chk("post_rst_instr0", 32'(instr), 32'h1234);
      tick();
      chk("post_rst_instr1", 32'(instr), 32'h5678);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
